// File: rtl/codec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codec_pkg
// Description : Shared constants for the codec sample transmitter: register
//               map, STATUS bit layout and serializer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package codec_pkg;

    localparam int DATA_W     = 24;
    localparam int ADDR_W     = 4;

    localparam logic [ADDR_W-1:0] ADDR_LEFT   = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_RIGHT  = 4'h1;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'h2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'h3;

    localparam int CTRL_EN_BIT  = 0;
    localparam int STAT_OVF_BIT = 0;
    localparam int STAT_UNR_BIT = 1;
    localparam int STAT_CNT_LSB = 2;
    localparam int STAT_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/codec_sample_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : codec_sample_tx_if
// Description : CPU-side write/read bus into the codec sample transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface codec_sample_tx_if;
    import codec_pkg::*;

    logic              codec_ce;
    logic              codec_re;
    logic [ADDR_W-1:0] codec_addr;
    logic [DATA_W-1:0] codec_data;
    logic [DATA_W-1:0] codec_rdata;

    modport master (
        output codec_ce,
        output codec_re,
        output codec_addr,
        output codec_data,
        input  codec_rdata
    );

    modport slave (
        input  codec_ce,
        input  codec_re,
        input  codec_addr,
        input  codec_data,
        output codec_rdata
    );
endinterface
`default_nettype wire

// File: rtl/codec_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module      : codec_pair_fifo
// Description : Synchronous stereo-pair FIFO; a pop in the same cycle as a
//               push lets the push succeed even when full.
// Revision    : 1.0 - initial release
// ============================================================================
module codec_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [3:0]       count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]       count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_q == 4'd0);
    assign full     = (count_q == 4'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Pop is evaluated first so a full FIFO can accept a simultaneous push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/codec_sample_tx.sv
`default_nettype none
// ============================================================================
// Module      : codec_sample_tx
// Description : Codec register endpoint, stereo-pair FIFO and left-justified
//               serializer driving bclk / lrclk / sdata to the audio DAC.
// Revision    : 1.0 - initial release
// ============================================================================
module codec_sample_tx
    import codec_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int SAMPLE_W   = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    codec_sample_tx_if.slave      bus,
    output logic                  dac_bclk,
    output logic                  dac_lrclk,
    output logic                  dac_sdata
);

    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int DIV_W   = $clog2(2 * CLK_DIV);
    localparam int BIT_W   = $clog2(FRAME_W);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HIGH  = DIV_W'(CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(SAMPLE_W);

    // Register file state
    logic [DATA_W-1:0]  left_hold_q, left_hold_d;
    logic               enable_q,    enable_d;
    logic               overflow_q,  overflow_d;
    logic               underrun_q,  underrun_d;
    logic [DATA_W-1:0]  rdata_q,     rdata_d;

    // Serializer state
    ser_state_e         state_q,     state_d;
    logic [DIV_W-1:0]   div_q,       div_d;
    logic [BIT_W-1:0]   bit_q,       bit_d;
    logic [FRAME_W-1:0] shreg_q,     shreg_d;
    logic               bclk_q,      bclk_d;
    logic               lrclk_q,     lrclk_d;
    logic               sdata_q,     sdata_d;

    logic               wr_left;
    logic               wr_right;
    logic               wr_ctrl;
    logic               wr_status;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [3:0]         fifo_count;
    logic [FRAME_W-1:0] fifo_rdata;
    logic               ovf_set;
    logic               unr_set;
    logic [DATA_W-1:0]  status_word;

    assign wr_left   = bus.codec_ce && (bus.codec_addr == ADDR_LEFT);
    assign wr_right  = bus.codec_ce && (bus.codec_addr == ADDR_RIGHT);
    assign wr_ctrl   = bus.codec_ce && (bus.codec_addr == ADDR_CTRL);
    assign wr_status = bus.codec_ce && (bus.codec_addr == ADDR_STATUS);

    assign ovf_set     = wr_right && fifo_full && !fifo_pop;
    assign status_word = {{(DATA_W - STAT_CNT_LSB - STAT_CNT_W){1'b0}},
                          fifo_count, underrun_q, overflow_q};

    codec_pair_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRAME_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_right),
        .push_data ({left_hold_q, bus.codec_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Register decode; reads use pre-write state so a same-cycle write is not visible.
    always_comb begin
        left_hold_d = left_hold_q;
        enable_d    = enable_q;
        overflow_d  = overflow_q;
        underrun_d  = underrun_q;
        rdata_d     = rdata_q;

        if (wr_left) begin
            left_hold_d = bus.codec_data;
        end
        if (wr_ctrl) begin
            enable_d = bus.codec_data[CTRL_EN_BIT];
        end
        if (wr_status && bus.codec_data[STAT_OVF_BIT]) begin
            overflow_d = 1'b0;
        end
        if (wr_status && bus.codec_data[STAT_UNR_BIT]) begin
            underrun_d = 1'b0;
        end
        // A new event wins over a clear arriving in the same cycle.
        if (ovf_set) begin
            overflow_d = 1'b1;
        end
        if (unr_set) begin
            underrun_d = 1'b1;
        end

        if (bus.codec_re) begin
            case (bus.codec_addr)
                ADDR_CTRL:   rdata_d = {{(DATA_W - 1){1'b0}}, enable_q};
                ADDR_STATUS: rdata_d = status_word;
                default:     rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        fifo_pop = 1'b0;
        unr_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (enable_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                div_d   = '0;
                bit_d   = '0;
                state_d = ST_SHIFT;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                end else begin
                    shreg_d = '0;
                    unr_set = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = enable_q ? ST_LOAD : ST_IDLE;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pins are registered from next-state values so they change cleanly at the edge.
    always_comb begin
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
        sdata_d = 1'b0;
        case (state_d)
            ST_SHIFT: begin
                bclk_d  = (div_d >= DIV_HIGH);
                lrclk_d = (bit_d >= BIT_RIGHT);
                sdata_d = shreg_d[FRAME_W-1];
            end
            ST_LOAD: begin
                sdata_d = sdata_q;
            end
            default: begin
                sdata_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            left_hold_q <= '0;
            enable_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
            rdata_q     <= '0;
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
        end else begin
            left_hold_q <= left_hold_d;
            enable_q    <= enable_d;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
            rdata_q     <= rdata_d;
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
        end
    end

    assign bus.codec_rdata = rdata_q;
    assign dac_bclk        = bclk_q;
    assign dac_lrclk       = lrclk_q;
    assign dac_sdata       = sdata_q;

endmodule
`default_nettype wire
